// File: rtl/verin_pkg.sv
// Shared constants and state type for the bar-angle acquisition path of the
// verin end-stop guard.
package verin_pkg;

   localparam int ADC_BITS            = 12;
   localparam int ADC_FRAME           = 15;
   localparam int ADC_FIRST_DATA_EDGE = 4;

   typedef enum logic [1:0] {
      IDLE,
      CS_SETUP,
      SHIFT,
      DONE
   } adc_state_t;

endpackage

// File: rtl/mcp3201_spi_rx.sv
// MCP3201 read-only SPI receiver: one 15-period SCLK frame per start pulse,
// 12 data bits captured MSB first and presented with a one-clock valid.
module mcp3201_spi_rx
   import verin_pkg::*;
#(
   parameter int SCLK_HALF = 25
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic                adc_miso,
   output logic                adc_cs_n,
   output logic                adc_sclk,
   output logic [ADC_BITS-1:0] angle,
   output logic                angle_valid
);

   localparam int DIV_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCLK_HALF - 1);
   localparam logic [4:0]       HALF_LAST  = 5'(2 * ADC_FRAME - 1);
   localparam logic [3:0]       FIRST_PAIR = 4'(ADC_FIRST_DATA_EDGE - 1);

   adc_state_t          state;
   logic [DIV_W-1:0]    div_cnt;
   logic [4:0]          half_cnt;
   logic [ADC_BITS-1:0] shift_reg;

   // half_cnt counts SCLK half-periods; half_cnt[4:1] is the number of rising
   // edges already issued, so a rise ending half 2k is edge k+1.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         adc_cs_n    <= 1'b1;
         adc_sclk    <= 1'b0;
         div_cnt     <= '0;
         half_cnt    <= '0;
         shift_reg   <= '0;
         angle       <= '0;
         angle_valid <= 1'b0;
      end else begin
         angle_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= CS_SETUP;
                  adc_cs_n <= 1'b0;
                  div_cnt  <= '0;
               end
            end
            CS_SETUP: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt  <= '0;
                  half_cnt <= '0;
                  state    <= SHIFT;
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            SHIFT: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt  <= '0;
                  adc_sclk <= ~adc_sclk;
                  if (!adc_sclk && (half_cnt[4:1] >= FIRST_PAIR))
                     shift_reg <= {shift_reg[ADC_BITS-2:0], adc_miso};
                  if (half_cnt == HALF_LAST) begin
                     adc_cs_n <= 1'b1;
                     state    <= DONE;
                  end else begin
                     half_cnt <= half_cnt + 1'b1;
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            DONE: begin
               angle       <= shift_reg;
               angle_valid <= 1'b1;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/verin_butee_guard.sv
// End-stop guard for the actuator: periodic angle acquisition, hysteretic
// fin_course flags against the software end-stops, and motor enable gating.
module verin_butee_guard
   import verin_pkg::*;
#(
   parameter int SCLK_HALF  = 25,
   parameter int ACQ_PERIOD = 500000,
   parameter int HYST       = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [ADC_BITS-1:0] butee_g,
   input  logic [ADC_BITS-1:0] butee_d,
   input  logic                sens,
   input  logic                enable_in,
   input  logic                adc_miso,
   output logic                adc_cs_n,
   output logic                adc_sclk,
   output logic [ADC_BITS-1:0] angle,
   output logic                angle_valid,
   output logic                fin_course_g,
   output logic                fin_course_d,
   output logic                enable_out
);

   localparam int PER_W = (ACQ_PERIOD > 1) ? $clog2(ACQ_PERIOD) : 1;
   localparam logic [PER_W-1:0]  PER_LAST = PER_W'(ACQ_PERIOD - 1);
   localparam logic [ADC_BITS:0] HYST_X   = (ADC_BITS + 1)'(HYST);
   localparam logic [ADC_BITS:0] ADC_MAX  = (ADC_BITS + 1)'((1 << ADC_BITS) - 1);

   logic [PER_W-1:0]  period_cnt;
   logic              start_q;
   logic              primed;
   logic [ADC_BITS:0] angle_x;
   logic [ADC_BITS:0] butee_d_x;
   logic [ADC_BITS:0] angle_plus_hyst;
   logic [ADC_BITS:0] g_sum;
   logic [ADC_BITS:0] g_clear_lvl;

   mcp3201_spi_rx #(.SCLK_HALF(SCLK_HALF)) u_spi_rx (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start_q),
      .adc_miso    (adc_miso),
      .adc_cs_n    (adc_cs_n),
      .adc_sclk    (adc_sclk),
      .angle       (angle),
      .angle_valid (angle_valid)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         period_cnt <= '0;
         start_q    <= 1'b0;
      end else begin
         start_q    <= (period_cnt == PER_LAST);
         period_cnt <= (period_cnt == PER_LAST) ? '0 : period_cnt + 1'b1;
      end
   end

   // Comparisons are done one bit wider so the hysteresis offsets never wrap;
   // the left clear level saturates at full scale so it can become unreachable.
   always_comb begin
      angle_x         = {1'b0, angle};
      butee_d_x       = {1'b0, butee_d};
      angle_plus_hyst = angle_x + HYST_X;
      g_sum           = {1'b0, butee_g} + HYST_X;
      g_clear_lvl     = (g_sum > ADC_MAX) ? ADC_MAX : g_sum;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fin_course_d <= 1'b0;
         fin_course_g <= 1'b0;
         primed       <= 1'b0;
      end else if (angle_valid) begin
         primed <= 1'b1;
         if (angle_x >= butee_d_x)
            fin_course_d <= 1'b1;
         else if (angle_plus_hyst < butee_d_x)
            fin_course_d <= 1'b0;
         if (angle <= butee_g)
            fin_course_g <= 1'b1;
         else if (angle_x > g_clear_lvl)
            fin_course_g <= 1'b0;
      end
   end

   // Both flags at once means the stops overlap, so no direction is safe.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         enable_out <= 1'b0;
      else
         enable_out <= primed & enable_in
                       & ~(sens ? fin_course_d : fin_course_g)
                       & ~(fin_course_d & fin_course_g);
   end

endmodule
